// File: rtl/alu_share_arbiter.sv
// Purpose : round-robin arbiter sharing one combinational ALU among NREQ requesters.
// Latency : acceptance edge to rsp_valid is 2 cycles (1 cycle for a rejected opcode
//           when ALU_ARB_OPCHK_EN is defined); at most one operation every 3 cycles.
// Backpressure: one operation in flight; req_ready only in IDLE; the response is held
//           stable until rsp_ready[owner].
// Ports   : req_* (valid/ready plus packed op/a/b per requester), rsp_* (one-hot
//           valid, shared data/zero/err), alu_* (to/from the external ALU), busy.
// Optional: define ALU_ARB_OPCHK_EN to reject opcodes the ALU does not implement.
module alu_share_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [4*NREQ-1:0]    req_op,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [31:0]          rsp_data,
    output logic                 rsp_zero,
    output logic                 rsp_err,
    output logic [3:0]           alu_control,
    output logic [31:0]          alu_a,
    output logic [31:0]          alu_b,
    input  logic [31:0]          alu_out,
    input  logic                 alu_zero,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [IDW-1:0] last_grant;
    logic [IDW-1:0] owner;
    logic [IDW-1:0] winner;
    logic [IDW-1:0] cand;
    logic           win_vld;
    logic           accept;
    logic [3:0]     win_op;
    logic [31:0]    win_a;
    logic [31:0]    win_b;
    int             idx;

    // Round-robin search starting just after last_grant. The loop runs from the
    // farthest candidate to the nearest so the nearest valid one is written last.
    always_comb begin
        winner  = last_grant;
        win_vld = 1'b0;
        cand    = '0;
        idx     = 0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = int'(last_grant) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            cand = IDW'(idx);
            if (req_valid[cand]) begin
                winner  = cand;
                win_vld = 1'b1;
            end
        end
    end

    assign win_op = req_op[int'(winner)*4 +: 4];
    assign win_a  = req_a[int'(winner)*32 +: 32];
    assign win_b  = req_b[int'(winner)*32 +: 32];
    assign accept = (state == IDLE) && win_vld;

`ifdef ALU_ARB_OPCHK_EN
    logic op_legal;

    always_comb begin
        case (win_op)
            4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12: op_legal = 1'b1;
            default:                             op_legal = 1'b0;
        endcase
    end
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rsp_valid = '0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    req_ready = NREQ'(1) << winner;
`ifdef ALU_ARB_OPCHK_EN
                    state_nxt = op_legal ? EXEC : RESP;
`else
                    state_nxt = EXEC;
`endif
                end
            end
            EXEC: begin
                busy      = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                busy      = 1'b1;
                rsp_valid = NREQ'(1) << owner;
                if (rsp_ready[owner]) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath. The alu_* registers double as the latched operands, so they
    // only change on a (legal) acceptance and hold their value otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant  <= IDW'(NREQ - 1);
            owner       <= '0;
            alu_control <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            rsp_data    <= '0;
            rsp_zero    <= 1'b0;
`ifdef ALU_ARB_OPCHK_EN
            rsp_err     <= 1'b0;
`endif
        end else begin
            if (accept) begin
                last_grant <= winner;
                owner      <= winner;
`ifdef ALU_ARB_OPCHK_EN
                if (op_legal) begin
                    alu_control <= win_op;
                    alu_a       <= win_a;
                    alu_b       <= win_b;
                    rsp_err     <= 1'b0;
                end else begin
                    // Rejected op: the response is formed here and the ALU is never touched.
                    rsp_data    <= '0;
                    rsp_zero    <= 1'b1;
                    rsp_err     <= 1'b1;
                end
`else
                alu_control <= win_op;
                alu_a       <= win_a;
                alu_b       <= win_b;
`endif
            end
            if (state == EXEC) begin
                rsp_data <= alu_out;
                rsp_zero <= alu_zero;
            end
        end
    end

`ifndef ALU_ARB_OPCHK_EN
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Purpose : directed self-checking bench for alu_share_arbiter with NREQ=2.
// Latency : inputs driven and outputs sampled on the falling edge.
// Backpressure: rsp_ready is driven per test to hold or release responses.
module tb_alu_share_arbiter;

    localparam int NREQ = 2;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [4*NREQ-1:0] req_op;
    logic [32*NREQ-1:0] req_a;
    logic [32*NREQ-1:0] req_b;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready;
    logic [31:0]       rsp_data;
    logic              rsp_zero;
    logic              rsp_err;
    logic [3:0]        alu_control;
    logic [31:0]       alu_a;
    logic [31:0]       alu_b;
    logic [31:0]       alu_out;
    logic              alu_zero;
    logic              busy;

    int n_chk = 0;
    int n_err = 0;

    alu_share_arbiter #(.NREQ(NREQ)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err),
        .alu_control(alu_control),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_out    (alu_out),
        .alu_zero   (alu_zero),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU standing in for the shared instance
    always_comb begin
        alu_out = '0;
        case (alu_control)
            4'd0:  alu_out = alu_a & alu_b;
            4'd1:  alu_out = alu_a | alu_b;
            4'd2:  alu_out = alu_a + alu_b;
            4'd6:  alu_out = alu_a - alu_b;
            4'd7:  alu_out = {31'd0, $signed(alu_a) < $signed(alu_b)};
            4'd12: alu_out = ~(alu_a | alu_b);
            default: alu_out = '0;
        endcase
        alu_zero = (alu_out == 32'd0);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b);
        req_op[4*i +: 4]  = op;
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Round-robin expectations, one entry per cycle, both requesters always valid
    logic [1:0]  rr_ready [12] = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00,
                                   2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
    logic [1:0]  rr_valid [12] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10,
                                   2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10};

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = '0;

        // Reset state
        step();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_alu_ctl", alu_control, 0);
        chk("rst_rsp_err", rsp_err, 0);
        rst_n = 1'b1;

        // Single op: 5 + 0xFFFFFFFD = 2
        step();
        set_req(0, 4'd2, 32'd5, 32'hFFFF_FFFD);
        req_valid = 2'b01;
        #1;
        chk("t1_req_ready", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        chk("t1_exec_busy", busy, 1);
        chk("t1_exec_rv", rsp_valid, 0);
        chk("t1_alu_ctl", alu_control, 2);
        chk("t1_alu_a", alu_a, 5);
        step();
        chk("t1_rsp_valid", rsp_valid, 2'b01);
        chk("t1_rsp_data", rsp_data, 2);
        chk("t1_rsp_zero", rsp_zero, 0);
        rsp_ready = 2'b01;
        step();
        rsp_ready = 2'b00;
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_rv", rsp_valid, 0);

        // Zero flag: 0x1234 - 0x1234
        set_req(1, 4'd6, 32'h1234, 32'h1234);
        req_valid = 2'b10;
        #1;
        chk("t2_req_ready", req_ready, 2'b10);
        step();
        req_valid = 2'b00;
        step();
        chk("t2_rsp_valid", rsp_valid, 2'b10);
        chk("t2_rsp_data", rsp_data, 0);
        chk("t2_rsp_zero", rsp_zero, 1);
        rsp_ready = 2'b10;
        step();

        // Round-robin: 0xF0F0 & 0xFF00 = 0xF000, 0x0F | 0xF0 = 0xFF
        set_req(0, 4'd0, 32'hF0F0, 32'hFF00);
        set_req(1, 4'd1, 32'h0F, 32'hF0);
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        for (int i = 0; i < 12; i++) begin
            if (i == 0) #1;
            else step();
            chk($sformatf("rr_ready_%0d", i), req_ready, rr_ready[i]);
            chk($sformatf("rr_valid_%0d", i), rsp_valid, rr_valid[i]);
            if (rr_valid[i] == 2'b01) chk($sformatf("rr_data_%0d", i), rsp_data, 32'hF000);
            if (rr_valid[i] == 2'b10) chk($sformatf("rr_data_%0d", i), rsp_data, 32'hFF);
        end
        req_valid = 2'b00;
        step();
        chk("rr_end_busy", busy, 0);
        rsp_ready = 2'b00;

        // Backpressure: 1 + 1 held for 5 RESP cycles with req0 still valid
        set_req(0, 4'd2, 32'd1, 32'd1);
        req_valid = 2'b01;
        #1;
        chk("bp_accept", req_ready, 2'b01);
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("bp_data_%0d", i), rsp_data, 2);
            chk($sformatf("bp_rdy_%0d", i), req_ready, 0);
            chk($sformatf("bp_busy_%0d", i), busy, 1);
            chk($sformatf("bp_rv_%0d", i), rsp_valid, 2'b01);
        end
        rsp_ready = 2'b10;
        step();
        chk("bp_nonowner_ignored", rsp_valid, 2'b01);
        rsp_ready = 2'b01;
        step();
        chk("bp_regrant", req_ready, 2'b01);
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        step();
        chk("bp_idle_busy", busy, 0);

        // Reset during EXEC discards the op
        set_req(0, 4'd2, 32'd7, 32'd8);
        req_valid = 2'b01;
        step();
        req_valid = 2'b00;
        chk("mr_exec_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mr_busy", busy, 0);
        chk("mr_rv", rsp_valid, 0);
        chk("mr_ready", req_ready, 0);
        chk("mr_alu_a", alu_a, 0);
        chk("mr_alu_ctl", alu_control, 0);
        chk("mr_data", rsp_data, 0);
        step();
        rst_n = 1'b1;
        set_req(1, 4'd2, 32'd3, 32'd4);
        req_valid = 2'b11;
        #1;
        chk("mr_restart_r0", req_ready, 2'b01);
        req_valid = 2'b10;
        #1;
        chk("mr_lone_r1", req_ready, 2'b10);
        step();
        req_valid = 2'b00;
        chk("mr_exec_rv", rsp_valid, 0);
        step();
        chk("mr_rsp_valid", rsp_valid, 2'b10);
        chk("mr_rsp_data", rsp_data, 7);
        rsp_ready = 2'b10;
        step();
        rsp_ready = 2'b00;

        // Unsupported opcode 3
        set_req(0, 4'd3, 32'd5, 32'd6);
        req_valid = 2'b01;
        #1;
        chk("op3_accept", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
`ifdef ALU_ARB_OPCHK_EN
        chk("op3_rv", rsp_valid, 2'b01);
        chk("op3_err", rsp_err, 1);
        chk("op3_data", rsp_data, 0);
        chk("op3_zero", rsp_zero, 1);
        chk("op3_alu_ctl", alu_control, 2);
`else
        chk("op3_exec_rv", rsp_valid, 0);
        chk("op3_alu_ctl", alu_control, 3);
        step();
        chk("op3_rv", rsp_valid, 2'b01);
        chk("op3_err", rsp_err, 0);
        chk("op3_data", rsp_data, 0);
        chk("op3_zero", rsp_zero, 1);
`endif
        rsp_ready = 2'b01;
        step();
        rsp_ready = 2'b00;
        chk("op3_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
